wb_arbiter: RTL and testbench

- Sequential write-back arbiter for the register file. It replaces fixed-priority combinational selection of execution-unit results.
- Six producers hand results over with a valid/ready handshake: ALU=0, STACK=1, UART=2, SCHED=3, JMP=4, DMA=5.
- Each producer has a one-entry holding buffer. A round-robin arbiter drains the buffers onto the single register-file write port, at most one write per cycle.
- Sits between the execution units and the register bank.

---
 rtl/wb_arbiter.sv | 88 ++++++++
 tb/tb_wb_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Round-robin write-back arbiter: six one-entry producer buffers drained onto
// the single register-file write port, at most one write per cycle.
module wb_arbiter #(
    parameter int unsigned N_SRC  = 6,
    parameter int unsigned CODE_W = 8,
    parameter int unsigned DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_SRC-1:0]           src_valid,
    output logic [N_SRC-1:0]           src_ready,
    input  logic [N_SRC*CODE_W-1:0]    src_code,
    input  logic [N_SRC*DATA_W-1:0]    src_value,
    input  logic                       reg_stall,
    output logic                       REG_write_back_flag,
    output logic [CODE_W-1:0]          REG_write_back_code,
    output logic [DATA_W-1:0]          REG_write_back_data,
    output logic [2:0]                 wb_src,
    output logic                       busy
);

    logic [N_SRC-1:0]  full;
    logic [N_SRC-1:0]  grant;
    logic [N_SRC-1:0]  capture;
    logic [CODE_W-1:0] buf_code [N_SRC];
    logic [DATA_W-1:0] buf_data [N_SRC];
    logic [2:0]        ptr;
    logic [2:0]        gidx;
    logic [2:0]        sidx;
    logic              found;
    int unsigned       scan;

    // First full buffer at or after ptr, wrapping; suppressed entirely while stalled.
    always_comb begin
        grant = '0;
        gidx  = '0;
        sidx  = '0;
        found = 1'b0;
        scan  = 0;
        if (!reg_stall) begin
            for (int unsigned k = 0; k < N_SRC; k++) begin
                scan = int'(ptr) + k;
                if (scan >= N_SRC) scan = scan - N_SRC;
                sidx = 3'(scan);
                if (!found && full[sidx]) begin
                    grant[sidx] = 1'b1;
                    gidx        = sidx;
                    found       = 1'b1;
                end
            end
        end
    end

    assign src_ready = ~full | grant;
    assign capture   = src_valid & src_ready;
    assign busy      = |full;

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (capture[i]) begin
                buf_code[i] <= src_code[i*CODE_W +: CODE_W];
                buf_data[i] <= src_value[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full                <= '0;
            ptr                 <= '0;
            REG_write_back_flag <= 1'b0;
            REG_write_back_code <= '0;
            REG_write_back_data <= '0;
            wb_src              <= '0;
        end else begin
            // A capture into the buffer being drained keeps it full with the new entry.
            full                <= capture | (full & ~grant);
            REG_write_back_flag <= found;
            if (found) begin
                REG_write_back_code <= buf_code[gidx];
                REG_write_back_data <= buf_data[gidx];
                wb_src              <= gidx;
                ptr                 <= (gidx == 3'(N_SRC - 1)) ? '0 : gidx + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: stimulus pushes expected writes into a queue,
// a negedge monitor pops and compares every write strobe.
module tb_wb_arbiter;

    localparam int unsigned N_SRC  = 6;
    localparam int unsigned CODE_W = 8;
    localparam int unsigned DATA_W = 32;

    typedef struct packed {
        logic [2:0]        src;
        logic [CODE_W-1:0] code;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [N_SRC-1:0]        src_valid;
    logic [N_SRC-1:0]        src_ready;
    logic [N_SRC*CODE_W-1:0] src_code;
    logic [N_SRC*DATA_W-1:0] src_value;
    logic                    reg_stall;
    logic                    flag;
    logic [CODE_W-1:0]       wcode;
    logic [DATA_W-1:0]       wdata;
    logic [2:0]              wb_src;
    logic                    busy;

    int  checks   = 0;
    int  failures = 0;
    wr_t exp_q[$];

    wb_arbiter #(.N_SRC(N_SRC), .CODE_W(CODE_W), .DATA_W(DATA_W)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .src_valid           (src_valid),
        .src_ready           (src_ready),
        .src_code            (src_code),
        .src_value           (src_value),
        .reg_stall           (reg_stall),
        .REG_write_back_flag (flag),
        .REG_write_back_code (wcode),
        .REG_write_back_data (wdata),
        .wb_src              (wb_src),
        .busy                (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && flag === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write: got src=%0d code=%0h data=%0h expected none",
                         wb_src, wcode, wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (wb_src !== e.src || wcode !== e.code || wdata !== e.data) begin
                    failures++;
                    $display("FAIL write: got src=%0d code=%0h data=%0h expected src=%0d code=%0h data=%0h",
                             wb_src, wcode, wdata, e.src, e.code, e.data);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        src_valid = '0;
        reg_stall = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic offer(input int i, input logic [CODE_W-1:0] c, input logic [DATA_W-1:0] v);
        src_valid[i] = 1'b1;
        src_code[i*CODE_W +: CODE_W]  = c;
        src_value[i*DATA_W +: DATA_W] = v;
    endtask

    task automatic expect_wr(input int i, input logic [CODE_W-1:0] c, input logic [DATA_W-1:0] v);
        wr_t e;
        e.src  = 3'(i);
        e.code = c;
        e.data = v;
        exp_q.push_back(e);
    endtask

    task automatic drain(input string name);
        for (int c = 0; c < 50 && exp_q.size() != 0; c++) step();
        step();
        chk(name, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    initial begin
        src_code  = '0;
        src_value = '0;
        src_valid = '0;
        reg_stall = 1'b0;
        rst_n     = 1'b0;
        step();

        // Reset state and single ALU write latency
        do_reset();
        chk("rst_flag",  64'(flag),      64'd0);
        chk("rst_code",  64'(wcode),     64'd0);
        chk("rst_data",  64'(wdata),     64'd0);
        chk("rst_src",   64'(wb_src),    64'd0);
        chk("rst_busy",  64'(busy),      64'd0);
        chk("rst_ready", 64'(src_ready), 64'h3f);
        offer(0, 8'h05, 32'hDEADBEEF);
        expect_wr(0, 8'h05, 32'hDEADBEEF);
        step();
        src_valid = '0;
        chk("lat_edge1_flag", 64'(flag), 64'd0);
        chk("lat_edge1_busy", 64'(busy), 64'd1);
        step();
        chk("lat_edge2_flag", 64'(flag), 64'd1);
        step();
        chk("one_shot_flag", 64'(flag), 64'd0);
        chk("idle_busy",     64'(busy), 64'd0);
        drain("drain_single");

        // All six at once: strobes 0..5 with no gaps
        do_reset();
        for (int i = 0; i < 6; i++) begin
            offer(i, 8'(i + 1), 32'h100 + 32'(i));
            expect_wr(i, 8'(i + 1), 32'h100 + 32'(i));
        end
        step();
        src_valid = '0;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("all6_flag", 64'(flag),   64'd1);
            chk("all6_src",  64'(wb_src), 64'(k));
        end
        step();
        chk("all6_end_flag", 64'(flag), 64'd0);
        drain("drain_all6");

        // ALU and DMA streaming: writes alternate 0,5,0,5,...
        do_reset();
        for (int k = 0; k < 5; k++) begin
            expect_wr(0, 8'h10 + 8'(k), 32'hA000_0000 + 32'(k));
            expect_wr(5, 8'h50 + 8'(k), 32'hD000_0000 + 32'(k));
        end
        begin
            int sent0 = 0;
            int sent5 = 0;
            logic [N_SRC-1:0] rdy;
            for (int c = 0; c < 40 && (sent0 < 5 || sent5 < 5); c++) begin
                src_valid = '0;
                if (sent0 < 5) offer(0, 8'h10 + 8'(sent0), 32'hA000_0000 + 32'(sent0));
                if (sent5 < 5) offer(5, 8'h50 + 8'(sent5), 32'hD000_0000 + 32'(sent5));
                rdy = src_ready;
                @(posedge clk);
                if (src_valid[0] && rdy[0]) sent0++;
                if (src_valid[5] && rdy[5]) sent5++;
                #1;
            end
            src_valid = '0;
            chk("rr_sent0", 64'(sent0), 64'd5);
            chk("rr_sent5", 64'(sent5), 64'd5);
        end
        drain("drain_rr");

        // Stall holds buffers 1 and 3; release drains 1 then 3
        do_reset();
        reg_stall = 1'b1;
        offer(1, 8'h31, 32'h1111_1111);
        offer(3, 8'h33, 32'h3333_3333);
        expect_wr(1, 8'h31, 32'h1111_1111);
        expect_wr(3, 8'h33, 32'h3333_3333);
        step();
        src_valid = '0;
        for (int k = 0; k < 4; k++) begin
            chk("stall_flag",   64'(flag),         64'd0);
            chk("stall_ready1", 64'(src_ready[1]), 64'd0);
            chk("stall_ready3", 64'(src_ready[3]), 64'd0);
            step();
        end
        reg_stall = 1'b0;
        drain("drain_stall");

        // JMP back-to-back: capture and drain in the same cycle
        for (int k = 1; k <= 8; k++) begin
            offer(4, 8'h40 + 8'(k), 32'(k));
            expect_wr(4, 8'h40 + 8'(k), 32'(k));
            chk("b2b_ready4", 64'(src_ready[4]), 64'd1);
            step();
        end
        src_valid = '0;
        drain("drain_b2b");

        // Reset mid-operation discards buffers and returns ptr to ALU
        offer(0, 8'h01, 32'h0000_0001);
        expect_wr(0, 8'h01, 32'h0000_0001);
        step();
        src_valid = '0;
        drain("drain_pre_mid");
        reg_stall = 1'b1;
        offer(0, 8'hE0, 32'hBAD0_0000);
        offer(2, 8'hE2, 32'hBAD0_0002);
        offer(4, 8'hE4, 32'hBAD0_0004);
        step();
        src_valid = '0;
        chk("mid_busy_before", 64'(busy), 64'd1);
        do_reset();
        chk("mid_busy", 64'(busy), 64'd0);
        chk("mid_flag", 64'(flag), 64'd0);
        offer(0, 8'h0A, 32'hAAAA_0000);
        offer(1, 8'h0B, 32'hBBBB_0001);
        expect_wr(0, 8'h0A, 32'hAAAA_0000);
        expect_wr(1, 8'h0B, 32'hBBBB_0001);
        step();
        src_valid = '0;
        drain("drain_mid");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
